// File: rtl/assoc_cache_pkg.sv
// Shared types and address geometry for the LC-3b set-associative cache.
package assoc_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } cache_state_t;

  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 4;

endpackage

// File: rtl/assoc_cache_set_array.sv
// One way's worth of per-set storage: asynchronous read, single write port.
module cache_set_array #(
  parameter int NUM_SETS  = 8,
  parameter int WIDTH     = 1,
  parameter bit HAS_RESET = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(NUM_SETS)-1:0] addr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [NUM_SETS];

  assign rdata = mem_q[addr];

  generate
    if (HAS_RESET) begin : g_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_SETS; i++) mem_q[i] <= '0;
        end else if (we) begin
          mem_q[addr] <= wdata;
        end
      end
    end else begin : g_norst
      // Payload arrays keep their contents through reset but never load while it is held.
      always_ff @(posedge clk) begin
        if (we && rst_n) mem_q[addr] <= wdata;
      end
    end
  endgenerate

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back cache with tree pseudo-LRU replacement.
module assoc_cache import assoc_cache_pkg::*; #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int LRU_W = NUM_WAYS - 1;

  function automatic lc3b_cacheline merge_bytes(lc3b_cacheline line, logic [2:0] word,
                                                lc3b_mem_wmask be, lc3b_word wdata);
    lc3b_cacheline mask;
    lc3b_cacheline data;
    mask = {112'h0, {8{be[1]}}, {8{be[0]}}} << {word, 4'h0};
    data = {112'h0, wdata} << {word, 4'h0};
    return (line & ~mask) | (data & mask);
  endfunction

  function automatic lc3b_word read_word(lc3b_cacheline line, logic [2:0] word);
    lc3b_cacheline sh;
    sh = line >> {word, 4'h0};
    return sh[15:0];
  endfunction

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 points right.
  function automatic logic [WAY_W-1:0] plru_victim(logic [LRU_W-1:0] tree);
    logic [7:0] t;
    logic [2:0] n;
    logic [2:0] way;
    t = 8'(tree);
    n = 3'd0;
    way = 3'd0;
    for (int l = 0; l < WAY_W; l++) begin
      way = {way[1:0], t[n]};
      n = (n << 1) + 3'd1 + {2'b00, t[n]};
    end
    return way[WAY_W-1:0];
  endfunction

  function automatic logic [LRU_W-1:0] plru_touch(logic [LRU_W-1:0] tree, logic [WAY_W-1:0] way);
    logic [7:0] t;
    logic [2:0] n;
    logic [2:0] s;
    logic       dir;
    t = 8'(tree);
    n = 3'd0;
    for (int l = 0; l < WAY_W; l++) begin
      s = 3'(way) >> (WAY_W - 1 - l);
      dir = s[0];
      t[n] = ~dir;
      n = (n << 1) + 3'd1 + {2'b00, dir};
    end
    return t[LRU_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  cache_state_t          state_q, state_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [IDX_W-1:0]      vidx_q, vidx_d;
  logic                  refill_q, refill_d;
  logic [15:0]           hit_count_q, hit_count_d;
  logic [15:0]           miss_count_q, miss_count_d;
  logic [LRU_W-1:0]      lru_q [NUM_SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx, arr_idx;
  lc3b_cacheline         data_rd [NUM_WAYS];
  logic [TAG_W-1:0]      tag_rd [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_rd, dirty_rd, hit_s;
  logic [NUM_WAYS-1:0]   data_we, tag_we, valid_we, dirty_we;
  lc3b_cacheline         data_wdata;
  logic                  dirty_wdata;
  logic [WAY_W-1:0]      hit_way, victim_s;
  logic [LRU_W-1:0]      lru_rd, lru_wdata;
  logic                  lru_we;
  logic                  unused_addr_bit;

  assign req_tag         = mem_address[15:OFFSET_W+IDX_W];
  assign req_idx         = mem_address[OFFSET_W+IDX_W-1:OFFSET_W];
  assign arr_idx         = (state_q == S_IDLE) ? req_idx : vidx_q;
  assign lru_rd          = lru_q[arr_idx];
  assign unused_addr_bit = mem_address[0];
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      cache_set_array #(.NUM_SETS(NUM_SETS), .WIDTH(128), .HAS_RESET(1'b0)) u_data (
        .clk(clk), .rst_n(rst_n), .we(data_we[w]), .addr(arr_idx),
        .wdata(data_wdata), .rdata(data_rd[w]));
      cache_set_array #(.NUM_SETS(NUM_SETS), .WIDTH(TAG_W), .HAS_RESET(1'b0)) u_tag (
        .clk(clk), .rst_n(rst_n), .we(tag_we[w]), .addr(arr_idx),
        .wdata(req_tag), .rdata(tag_rd[w]));
      cache_set_array #(.NUM_SETS(NUM_SETS), .WIDTH(1), .HAS_RESET(1'b1)) u_valid (
        .clk(clk), .rst_n(rst_n), .we(valid_we[w]), .addr(arr_idx),
        .wdata(1'b1), .rdata(valid_rd[w]));
      cache_set_array #(.NUM_SETS(NUM_SETS), .WIDTH(1), .HAS_RESET(1'b1)) u_dirty (
        .clk(clk), .rst_n(rst_n), .we(dirty_we[w]), .addr(arr_idx),
        .wdata(dirty_wdata), .rdata(dirty_rd[w]));
      assign hit_s[w] = valid_rd[w] && (tag_rd[w] == req_tag);
    end
  endgenerate

  always_comb begin
    hit_way  = '0;
    victim_s = plru_victim(lru_rd);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_way  = hit_s[w] ? WAY_W'(w) : hit_way;
      victim_s = valid_rd[w] ? victim_s : WAY_W'(w);
    end
  end

  // refill_q marks the response that completes a miss so it is not also counted as a hit.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    vidx_d       = vidx_q;
    refill_d     = refill_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    data_we      = '0;
    tag_we       = '0;
    valid_we     = '0;
    dirty_we     = '0;
    data_wdata   = pmem_rdata;
    dirty_wdata  = 1'b0;
    lru_we       = 1'b0;
    lru_wdata    = lru_rd;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        refill_d = 1'b0;
        if ((mem_read || mem_write) && (|hit_s)) begin
          mem_resp    = 1'b1;
          lru_we      = 1'b1;
          lru_wdata   = plru_touch(lru_rd, hit_way);
          hit_count_d = refill_q ? hit_count_q : sat_inc(hit_count_q);
          if (mem_write) begin
            data_we[hit_way]  = 1'b1;
            data_wdata        = merge_bytes(data_rd[hit_way], mem_address[3:1],
                                            mem_byte_enable, mem_wdata);
            dirty_we[hit_way] = 1'b1;
            dirty_wdata       = 1'b1;
          end else begin
            mem_rdata = read_word(data_rd[hit_way], mem_address[3:1]);
          end
        end else if (mem_read || mem_write) begin
          victim_d     = victim_s;
          vidx_d       = req_idx;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = (valid_rd[victim_s] && dirty_rd[victim_s]) ? S_WRITEBACK : S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd[victim_q], vidx_q, 4'h0};
        pmem_wdata   = data_rd[victim_q];
        state_d      = pmem_resp ? S_FILL : S_WRITEBACK;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'h0};
        if (pmem_resp) begin
          data_we[victim_q]  = 1'b1;
          tag_we[victim_q]   = 1'b1;
          valid_we[victim_q] = 1'b1;
          dirty_we[victim_q] = 1'b1;
          lru_we             = 1'b1;
          lru_wdata          = plru_touch(lru_rd, victim_q);
          refill_d           = 1'b1;
          state_d            = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      victim_q     <= '0;
      vidx_q       <= '0;
      refill_q     <= 1'b0;
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
      for (int i = 0; i < NUM_SETS; i++) lru_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      vidx_q       <= vidx_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (lru_we) lru_q[arr_idx] <= lru_wdata;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (4 ways, 8 sets) with a latency-modelled physical memory.
module tb_assoc_cache;

  localparam int LAT = 3;

  logic         clk, rst_n, mem_read, mem_write, mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  mem_address, mem_wdata, mem_rdata, pmem_address, hit_count, miss_count;
  logic [1:0]   mem_byte_enable;
  logic [127:0] pmem_rdata, pmem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] pmem [logic [15:0]];
  logic [16:0]  plog [$];

  assoc_cache #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .hit_count(hit_count),
    .miss_count(miss_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a | 16'(k);
    return l;
  endfunction

  function automatic logic [127:0] get_line(input logic [15:0] a);
    if (pmem.exists(a)) return pmem[a];
    return pat_line(a);
  endfunction

  initial begin : responder
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= LAT) begin
          pmem_resp = 1'b1;
          plog.push_back({pmem_write, pmem_address});
          if (pmem_write) pmem[pmem_address] = pmem_wdata;
          else pmem_rdata = get_line(pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cpu_access(input bit wr, input logic [15:0] a, input logic [1:0] be,
                            input logic [15:0] wd, output logic [15:0] rd, output int cyc);
    @(negedge clk);
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    mem_read = !wr;
    mem_write = wr;
    cyc = 0;
    #1;
    while (!mem_resp && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!mem_resp) check_eq("resp_timeout", {31'b0, mem_resp}, 32'd1);
    rd = mem_rdata;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  rd;
    logic [127:0] line;
    int           cyc;
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 16'h0000;
    mem_byte_enable = 2'b00;
    mem_wdata = 16'h0000;
    line = pat_line(16'h1230);
    line[47:32] = 16'hBEEF;
    pmem[16'h1230] = line;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    check_eq("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check_eq("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    check_eq("rst_pmem_addr", {16'b0, pmem_address}, 32'd0);
    check_eq("rst_rdata", {16'b0, mem_rdata}, 32'd0);
    check_eq("rst_hits", {16'b0, hit_count}, 32'd0);
    check_eq("rst_misses", {16'b0, miss_count}, 32'd0);
    rst_n = 1'b1;

    // Cold read miss, no writeback
    plog.delete();
    cpu_access(1'b0, 16'h1234, 2'b00, 16'h0000, rd, cyc);
    check_eq("cold_rdata", {16'b0, rd}, 32'h0000BEEF);
    check_eq("cold_latency", cyc, 32'd4);
    check_eq("cold_nlog", plog.size(), 32'd1);
    check_eq("cold_fill_addr", {15'b0, plog[0]}, {15'b0, 1'b0, 16'h1230});
    check_eq("cold_misses", {16'b0, miss_count}, 32'd1);
    check_eq("cold_hits", {16'b0, hit_count}, 32'd0);

    // Write hit low byte, then read back the merged word
    cpu_access(1'b1, 16'h1234, 2'b01, 16'h00AA, rd, cyc);
    check_eq("wr_latency", cyc, 32'd0);
    cpu_access(1'b0, 16'h1234, 2'b00, 16'h0000, rd, cyc);
    check_eq("rd_merge", {16'b0, rd}, 32'h0000BEAA);
    check_eq("rd_latency", cyc, 32'd0);
    check_eq("merge_hits", {16'b0, hit_count}, 32'd2);
    check_eq("merge_misses", {16'b0, miss_count}, 32'd1);

    // Fill the remaining three ways of set 3
    cpu_access(1'b0, 16'h00B6, 2'b00, 16'h0000, rd, cyc);
    check_eq("fill1_rdata", {16'b0, rd}, 32'h000000B3);
    cpu_access(1'b0, 16'h0130, 2'b00, 16'h0000, rd, cyc);
    check_eq("fill2_rdata", {16'b0, rd}, 32'h00000130);
    cpu_access(1'b0, 16'h01B2, 2'b00, 16'h0000, rd, cyc);
    check_eq("fill3_rdata", {16'b0, rd}, 32'h000001B1);

    // Fifth tag: PLRU picks way 0, which is dirty, so writeback precedes the fill
    plog.delete();
    cpu_access(1'b0, 16'h0230, 2'b00, 16'h0000, rd, cyc);
    check_eq("evict_rdata", {16'b0, rd}, 32'h00000230);
    check_eq("evict_latency", cyc, 32'd8);
    check_eq("evict_nlog", plog.size(), 32'd2);
    if (plog.size() == 2) begin
      check_eq("evict_wb_first", {15'b0, plog[0]}, {15'b0, 1'b1, 16'h1230});
      check_eq("evict_fill_next", {15'b0, plog[1]}, {15'b0, 1'b0, 16'h0230});
    end
    line = get_line(16'h1230);
    check_eq("wb_word2", {16'b0, line[47:32]}, 32'h0000BEAA);
    check_eq("wb_word0", {16'b0, line[15:0]}, 32'h00001230);
    check_eq("evict_misses", {16'b0, miss_count}, 32'd5);
    check_eq("evict_hits", {16'b0, hit_count}, 32'd2);

    // Re-read the evicted line: clean victim, data comes back from the writeback
    cpu_access(1'b0, 16'h1234, 2'b00, 16'h0000, rd, cyc);
    check_eq("reread_rdata", {16'b0, rd}, 32'h0000BEAA);
    check_eq("reread_latency", cyc, 32'd4);
    check_eq("reread_misses", {16'b0, miss_count}, 32'd6);

    // Reset in the middle of a fill
    @(negedge clk);
    mem_address = 16'h0456;
    mem_read = 1'b1;
    @(negedge clk);
    #1;
    check_eq("fill_pmem_read", {31'b0, pmem_read}, 32'd1);
    check_eq("fill_pmem_addr", {16'b0, pmem_address}, 32'h00000450);
    check_eq("fill_no_resp", {31'b0, mem_resp}, 32'd0);
    check_eq("fill_rdata_zero", {16'b0, mem_rdata}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_pmem_read", {31'b0, pmem_read}, 32'd0);
    check_eq("abort_misses", {16'b0, miss_count}, 32'd0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_access(1'b0, 16'h0456, 2'b00, 16'h0000, rd, cyc);
    check_eq("post_rst_latency", cyc, 32'd4);
    check_eq("post_rst_rdata", {16'b0, rd}, 32'h00000453);
    check_eq("post_rst_misses", {16'b0, miss_count}, 32'd1);
    check_eq("post_rst_hits", {16'b0, hit_count}, 32'd0);

    // Back-to-back hits drive hit_count into saturation
    @(negedge clk);
    mem_address = 16'h0456;
    mem_read = 1'b1;
    repeat (65530) @(posedge clk);
    #1;
    check_eq("hits_65530", {16'b0, hit_count}, 32'd65530);
    repeat (10) @(posedge clk);
    #1;
    check_eq("hits_saturated", {16'b0, hit_count}, 32'h0000FFFF);
    check_eq("sat_resp", {31'b0, mem_resp}, 32'd1);
    check_eq("sat_rdata", {16'b0, mem_rdata}, 32'h00000453);
    check_eq("sat_misses", {16'b0, miss_count}, 32'd1);
    mem_read = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
